// File: rtl/cal_eep_pkg.sv
// Shared types and constants for the calibration EEPROM SPI responder.
package cal_eep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DECODE,
        BUSY
    } state_t;

    localparam logic [1:0]  OP_RD     = 2'b00;
    localparam logic [1:0]  OP_WR     = 2'b01;
    localparam logic [15:0] BUSY_RESP = 16'hFFFF;

    localparam logic [4:0]  FRAME_LEN = 5'd16;
    localparam logic [4:0]  CNT_SAT   = 5'd17;

    function automatic logic [4:0] sat_inc(input logic [4:0] c);
        return (c == CNT_SAT) ? c : c + 5'd1;
    endfunction

endpackage

// File: rtl/cal_eep_spi_slave_sync.sv
// Two-flop synchroniser with single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= RST_VAL;
            s2_q  <= RST_VAL;
            dly_q <= RST_VAL;
        end else begin
            s1_q  <= d_i;
            s2_q  <= s1_q;
            dly_q <= s2_q;
        end
    end

    assign rise_o =  s2_q & ~dly_q;
    assign fall_o = ~s2_q &  dly_q;

endmodule

// File: rtl/cal_eep_spi_slave.sv
// SPI responder model of the 64x8 calibration EEPROM.
import cal_eep_pkg::*;

module cal_eep_spi_slave #(
    parameter int WR_CYCLES = 16,
    parameter int DEPTH     = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic SCLK,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic frame_err
);

    localparam int TW = $clog2(WR_CYCLES + 1);

    logic sclk_rise, sclk_fall;
    logic ss_rise, ss_fall;
    logic mosi_s1_q, mosi_q;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk    (clk),
        .rst    (rst),
        .d_i    (SCLK),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
        .clk    (clk),
        .rst    (rst),
        .d_i    (SS_n),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_s1_q <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            mosi_s1_q <= MOSI;
            mosi_q    <= mosi_s1_q;
        end
    end

    state_t          state_q;
    logic [15:0]     resp_q, sout_q, sin_q;
    logic [4:0]      cnt_q;
    logic            miso_q, busy_q, ferr_q;
    logic            bfrm_q;
    logic [TW-1:0]   timer_q;
    logic [5:0]      waddr_q;
    logic [7:0]      wdata_q;
    logic [7:0]      mem [DEPTH];

    logic [TW-1:0]   timer_d;
    logic [1:0]      op;
    logic [5:0]      addr;
    logic            wr_done;

    assign timer_d = timer_q - TW'(1);
    assign op      = sin_q[15:14];
    assign addr    = sin_q[13:8];
    assign wr_done = (state_q == BUSY) && (timer_d == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            resp_q  <= '0;
            sout_q  <= '0;
            sin_q   <= '0;
            cnt_q   <= '0;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            bfrm_q  <= 1'b0;
            timer_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            ferr_q <= 1'b0;
            // A frame begun while busy answers all ones and is never decoded
            if (bfrm_q && ss_rise) begin
                bfrm_q <= 1'b0;
                resp_q <= BUSY_RESP;
                miso_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (ss_fall && !bfrm_q) begin
                        state_q <= SHIFT;
                        sout_q  <= {resp_q[14:0], 1'b0};
                        miso_q  <= resp_q[15];
                        sin_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        sin_q <= {sin_q[14:0], mosi_q};
                        cnt_q <= sat_inc(cnt_q);
                    end
                    if (sclk_fall) begin
                        miso_q <= sout_q[15];
                        sout_q <= {sout_q[14:0], 1'b0};
                    end
                    if (ss_rise) begin
                        state_q <= DECODE;
                        miso_q  <= 1'b0;
                    end
                end
                DECODE: begin
                    state_q <= IDLE;
                    resp_q  <= '0;
                    if (cnt_q != FRAME_LEN) begin
                        ferr_q <= 1'b1;
                    end else if (op == OP_RD) begin
                        resp_q <= {8'h00, mem[addr]};
                    end else if (op == OP_WR) begin
                        waddr_q <= addr;
                        wdata_q <= sin_q[7:0];
                        busy_q  <= 1'b1;
                        timer_q <= TW'(WR_CYCLES);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    timer_q <= timer_d;
                    if (ss_fall) begin
                        bfrm_q <= 1'b1;
                        miso_q <= 1'b1;
                    end
                    if (wr_done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_done) begin
            mem[waddr_q] <= wdata_q;
        end
    end

    assign MISO      = miso_q;
    assign busy      = busy_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_cal_eep_spi_slave.sv
// Directed self-checking bench for the calibration EEPROM SPI responder.
module tb_cal_eep_spi_slave;

    localparam int WRC = 16;

    logic clk = 1'b0;
    logic rst;
    logic SCLK, SS_n, MOSI;
    logic MISO, busy, frame_err;

    int checks = 0;
    int errors = 0;
    int busy_cyc = 0;
    int ferr_cnt = 0;

    cal_eep_spi_slave #(.WR_CYCLES(WRC), .DEPTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .SCLK      (SCLK),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (busy === 1'b1) busy_cyc++;
        if (frame_err === 1'b1) ferr_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] tx, input int nbits,
                        output logic [15:0] rx);
        rx = '0;
        SS_n = 1'b0;
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? tx[15-i] : 1'b0;
            tick(5);
            SCLK = 1'b1;
            if (i < 16) rx[15-i] = MISO;
            tick(5);
            SCLK = 1'b0;
        end
        tick(5);
        SS_n = 1'b1;
        tick(6);
    endtask

    task automatic frame(input string tag, input logic [15:0] tx,
                         input int nbits, input logic [15:0] exp);
        logic [15:0] rx;
        send(tx, nbits, rx);
        check(tag, rx, exp);
    endtask

    initial begin
        int b0, f0;
        rst = 1'b1;
        SCLK = 1'b0;
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick(3);
        check("rst_miso", 16'(MISO), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_ferr", 16'(frame_err), 16'h0);
        check("rst_state", 16'(dut.state_q), 16'(cal_eep_pkg::IDLE));
        rst = 1'b0;
        tick(3);

        // 1: write then read back through a dummy frame
        b0 = busy_cyc;
        frame("t1_wr", 16'h4A5C, 16, 16'h0000);
        check("t1_busy_hi", 16'(busy), 16'h1);
        tick(WRC + 4);
        check("t1_busy_lo", 16'(busy), 16'h0);
        check("t1_busy_len", 16'(busy_cyc - b0), 16'(WRC));
        frame("t1_rd", 16'h0A00, 16, 16'h0000);
        frame("t1_dummy", 16'hBCBC, 16, 16'h005C);
        check("t1_miso_idle", 16'(MISO), 16'h0);

        // 2: second write lands while busy and is ignored
        f0 = ferr_cnt;
        frame("t2_wr", 16'h4133, 16, 16'h0000);
        frame("t2_busy_frm", 16'h4177, 16, 16'hFFFF);
        tick(25);
        check("t2_busy_lo", 16'(busy), 16'h0);
        frame("t2_rd", 16'h0100, 16, 16'hFFFF);
        frame("t2_dummy", 16'hBCBC, 16, 16'h0033);
        check("t2_no_ferr", 16'(ferr_cnt - f0), 16'h0);

        // 3: short frame is discarded
        frame("t3_wr", 16'h42AA, 16, 16'h0000);
        tick(WRC + 4);
        f0 = ferr_cnt;
        frame("t3_short", 16'h4255, 12, 16'h0000);
        check("t3_ferr", 16'(ferr_cnt - f0), 16'h1);
        frame("t3_rd", 16'h0200, 16, 16'h0000);
        frame("t3_dummy", 16'hBCBC, 16, 16'h00AA);

        // 4: long frame is discarded
        f0 = ferr_cnt;
        b0 = busy_cyc;
        frame("t4_long", 16'h4255, 18, 16'h0000);
        check("t4_ferr", 16'(ferr_cnt - f0), 16'h1);
        check("t4_no_busy", 16'(busy_cyc - b0), 16'h0);
        frame("t4_rd", 16'h0200, 16, 16'h0000);
        frame("t4_dummy", 16'hBCBC, 16, 16'h00AA);

        // 5: reset in the middle of a write frame
        SS_n = 1'b0;
        tick(6);
        for (int i = 0; i < 8; i++) begin
            MOSI = i[0];
            tick(5);
            SCLK = 1'b1;
            tick(5);
            SCLK = 1'b0;
        end
        rst = 1'b1;
        tick(2);
        check("t5_miso", 16'(MISO), 16'h0);
        check("t5_busy", 16'(busy), 16'h0);
        check("t5_state", 16'(dut.state_q), 16'(cal_eep_pkg::IDLE));
        SS_n = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);
        frame("t5_rd", 16'h0200, 16, 16'h0000);
        frame("t5_dummy", 16'hBCBC, 16, 16'h00AA);

        // 6: back-to-back reads and reserved opcodes
        frame("t6_wr", 16'h4312, 16, 16'h0000);
        tick(WRC + 4);
        frame("t6_rd1", 16'h0300, 16, 16'h0000);
        frame("t6_rd2", 16'h0300, 16, 16'h0012);
        frame("t6_dummy", 16'hBCBC, 16, 16'h0012);
        frame("t6_rd3", 16'h0300, 16, 16'h0000);
        frame("t6_rsvd", 16'hC000, 16, 16'h0012);
        frame("t6_after", 16'hBCBC, 16, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
